// File: rtl/rs_dispatch_pkg.sv
// Shared constants and types for the rename-to-reservation-station dispatch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rs_dispatch_pkg;

   localparam int NUM_RS    = 4;
   localparam int RS_DEPTH  = 32;
   localparam int PAYLOAD_W = 127;
   localparam int SEQ_W     = 32;
   localparam int CNT_W     = $clog2(RS_DEPTH + 1);
   localparam int STALL_W   = 32;
   localparam int FU_SEL_W  = 2;

   // FU class index doubles as the reservation-station index
   localparam logic [FU_SEL_W-1:0] FU_ALU = 2'd0;
   localparam logic [FU_SEL_W-1:0] FU_MUL = 2'd1;
   localparam logic [FU_SEL_W-1:0] FU_DIV = 2'd2;
   localparam logic [FU_SEL_W-1:0] FU_BR  = 2'd3;

   // Credit update encoding, packed as {inc, dec}
   typedef enum logic [1:0] {
      CR_HOLD = 2'b00,
      CR_DEC  = 2'b01,
      CR_INC  = 2'b10,
      CR_BOTH = 2'b11
   } credit_op_e;

   function automatic logic [NUM_RS-1:0] fu_onehot(input logic [FU_SEL_W-1:0] sel);
      logic [NUM_RS-1:0] oh;
      oh      = '0;
      oh[sel] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/rs_dispatch_ctrl_if.sv
// Rename-side handshake plus the shared RS write bus and RS issue-return strobes.
// Latency: n/a (wiring only).
// Backpressure: in_ready is the only stall signal toward rename.
interface rs_dispatch_ctrl_if;
   import rs_dispatch_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [FU_SEL_W-1:0]  in_fu_sel;
   logic [PAYLOAD_W-1:0] in_payload;
   logic [NUM_RS-1:0]    rs_start;
   logic [PAYLOAD_W-1:0] rs_payload;
   logic [SEQ_W-1:0]     rs_seq;
   logic [NUM_RS-1:0]    rs_issue;

   // Rename stage and reservation stations
   modport master (
      output in_valid, in_fu_sel, in_payload, rs_issue,
      input  in_ready, rs_start, rs_payload, rs_seq
   );

   // Dispatch controller
   modport slave (
      input  in_valid, in_fu_sel, in_payload, rs_issue,
      output in_ready, rs_start, rs_payload, rs_seq
   );

endinterface

// File: rtl/rs_credit_counter.sv
// Free-entry credit counter for one reservation station; flush refills to RS_DEPTH.
// Latency: count updates at the edge after inc/dec; overflow is a same-cycle flag.
// Backpressure: nonzero gates acceptance for this RS; an inc at full is held and flagged.
module rs_credit_counter
   import rs_dispatch_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             nonzero,
   output logic             overflow
);

   credit_op_e op;
   logic       full;

   assign op       = credit_op_e'({inc, dec});
   assign full     = (count == CNT_W'(RS_DEPTH));
   assign nonzero  = (count != '0);
   // A return with no free slot to give back means the RS and controller disagree
   assign overflow = !flush && (op == CR_INC) && full;

   // Credit register: reset and flush refill, otherwise apply the {inc,dec} delta
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         count <= CNT_W'(RS_DEPTH);
      end else begin
         case (op)
            CR_DEC:  count <= count - CNT_W'(1);
            CR_INC:  if (!full) count <= count + CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rs_dispatch_ctrl.sv
// Steers renamed instructions to one of NUM_RS reservation stations with a sequence stamp; optional RS_DISPATCH_PERF_EN adds per-RS stall counters.
// Latency: accept in cycle N gives a one-cycle rs_start pulse in N+1; back-to-back accepts need no bubbles.
// Backpressure: in_ready drops combinationally when the selected RS has no credit, or during reset/flush.
module rs_dispatch_ctrl
   import rs_dispatch_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   rs_dispatch_ctrl_if.slave         bus,
   output logic [NUM_RS*CNT_W-1:0]   credit_out,
   output logic                      credit_err,
   output logic [NUM_RS*STALL_W-1:0] stall_cnt
);

   logic [NUM_RS-1:0] sel_oh;
   logic [NUM_RS-1:0] dec_vec;
   logic [NUM_RS-1:0] cr_nonzero;
   logic [NUM_RS-1:0] cr_overflow;
   logic [CNT_W-1:0]  cr_count [NUM_RS];
   logic [SEQ_W-1:0]  seq_cnt;
   logic              accept;

   assign sel_oh       = fu_onehot(bus.in_fu_sel);
   assign bus.in_ready = !reset && !flush && cr_nonzero[bus.in_fu_sel];
   assign accept       = bus.in_valid && bus.in_ready;
   assign dec_vec      = accept ? sel_oh : '0;

   for (genvar k = 0; k < NUM_RS; k++) begin : g_rs
      rs_credit_counter u_credit (
         .clk      (clk),
         .reset    (reset),
         .flush    (flush),
         .inc      (bus.rs_issue[k]),
         .dec      (dec_vec[k]),
         .count    (cr_count[k]),
         .nonzero  (cr_nonzero[k]),
         .overflow (cr_overflow[k])
      );
      assign credit_out[k*CNT_W +: CNT_W] = cr_count[k];
   end

   // Write strobe, payload/sequence capture and sticky credit error
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.rs_start   <= '0;
         bus.rs_payload <= '0;
         bus.rs_seq     <= '0;
         seq_cnt        <= '0;
         credit_err     <= 1'b0;
      end else begin
         // accept is already low during flush, so flush also kills the pulse
         bus.rs_start <= dec_vec;
         if (accept) begin
            bus.rs_payload <= bus.in_payload;
            bus.rs_seq     <= seq_cnt;
            seq_cnt        <= seq_cnt + SEQ_W'(1);
         end
         if (|cr_overflow) begin
            credit_err <= 1'b1;
         end
      end
   end

`ifdef RS_DISPATCH_PERF_EN
   logic [STALL_W-1:0] stall_q [NUM_RS];

   for (genvar k = 0; k < NUM_RS; k++) begin : g_perf
      // Count cycles rename is blocked solely because this RS is full; saturate
      always_ff @(posedge clk) begin
         if (reset) begin
            stall_q[k] <= '0;
         end else if (!flush && bus.in_valid && sel_oh[k] && !cr_nonzero[k]
                      && (stall_q[k] != '1)) begin
            stall_q[k] <= stall_q[k] + STALL_W'(1);
         end
      end
      assign stall_cnt[k*STALL_W +: STALL_W] = stall_q[k];
   end
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: doc/rs_dispatch_ctrl.md
Name: rs_dispatch_ctrl

Overview:
Dispatch scheduler between rename and the reservation stations (ALU, MUL, DIV, BR). It steers each renamed instruction to exactly one RS via a one-cycle start pulse and stamps a monotonic dispatch sequence number. It tracks free entries per RS with credit counters, and back-pressures rename when the target RS is full. Exception/mret flush restores all credits, matching the RS flush that clears all entries.

Parameters:
NUM_RS, 4, number of reservation stations; index = FU class.
RS_DEPTH, 32, entries per RS; initial and maximum credit.
PAYLOAD_W, 127, width of the opaque instruction payload forwarded to the RS.
SEQ_W, 32, width of the dispatch sequence number.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  exception_sig | mret_sig; synchronous pipeline flush
in_valid  in  1  rename has an instruction
in_ready  out  1  controller accepts this cycle
in_fu_sel  in  2  target RS class: 0=ALU, 1=MUL, 2=DIV, 3=BR
in_payload  in  PAYLOAD_W  instruction fields, forwarded unmodified
rs_start  out  NUM_RS  one-hot write strobe to the selected RS
rs_payload  out  PAYLOAD_W  registered payload, shared by all RS
rs_seq  out  SEQ_W  dispatch sequence number for this write (RS inst_num)
rs_issue  in  NUM_RS  bit k: RS k freed one entry this cycle (issued to FU)
credit_out  out  NUM_RS*6  free-entry count per RS, RS k at [6k+5:6k]
credit_err  out  1  sticky: rs_issue with credit already at RS_DEPTH
stall_cnt  out  NUM_RS*32  per-RS full-stall cycle counters (optional feature)

Behaviour:
- Reset (sync): credit[k]=RS_DEPTH, rs_start=0, rs_payload=0, rs_seq=0, seq counter=0, credit_err=0, stall_cnt=0.
- in_ready = !reset & !flush & (credit[in_fu_sel] != 0). Combinational on in_fu_sel, so rename holds in_fu_sel and in_payload stable while in_valid=1.
- Accept = in_valid & in_ready.
  - Next edge: rs_start[in_fu_sel]=1, other bits 0.
  - rs_payload <= in_payload; rs_seq <= seq counter; seq counter += 1 (wraps at 2^SEQ_W).
- Latency: accept in cycle N -> rs_start high for exactly cycle N+1. Back-to-back accepts give consecutive pulses; no bubbles.
- No accept: rs_start=0 next cycle. rs_payload and rs_seq hold their last values.
- Credit update per RS k, applied at the edge:
  - dec = accept & (in_fu_sel==k); inc = rs_issue[k].
  - dec&inc -> unchanged; dec only -> -1; inc only -> +1.
- Boundary conditions:
  - credit 0 -> in_ready=0 for that class only; other classes still accept.
  - credit 1 with accept and no issue -> 0 next cycle.
  - credit 0 with rs_issue -> 1 next cycle; in_ready rises in that next cycle, not combinationally in the issue cycle.
- Overflow: inc with credit==RS_DEPTH and no dec -> credit holds, credit_err <= 1. credit_err is cleared only by reset.
- Flush (priority over accept and rs_issue):
  - Next edge: credit[k]=RS_DEPTH, rs_start=0.
  - An accept is impossible in the flush cycle (in_ready=0).
  - The seq counter is not cleared; sequence numbers stay monotonic across flushes. credit_err is kept.
- Reset has priority over flush. Reset mid-stream drops any pending start pulse.
- Credit width is 6 bits for RS_DEPTH=32; generally $clog2(RS_DEPTH+1).

Optional Feature:
- Macro: RS_DISPATCH_PERF_EN.
- Defined: per-RS 32-bit counter stall_cnt[k] increments each cycle with in_valid=1, in_fu_sel=k, credit[k]==0, no reset/flush. Saturates at 0xFFFFFFFF. Cleared by reset only.
- Undefined: stall_cnt tied to 0 and no counter flops are built.

Decomposition:
- Package rs_dispatch_pkg holds:
  - FU class constants FU_ALU=0, FU_MUL=1, FU_DIV=2, FU_BR=3.
  - RS_DEPTH, CNT_W=$clog2(RS_DEPTH+1), SEQ_W.
  - Credit update encoding {inc,dec}.
- Sub-module rs_credit_counter: one per RS via generate. Inputs inc, dec, flush; outputs count, nonzero, overflow.

Test Plan:
- Reset then 3 accepts to ALU in cycles 1-3 -> rs_start=4'b0001 in cycles 2-4, rs_seq=0,1,2; credit_out ALU=29.
- 32 accepts to MUL, none issued -> credit MUL=0, in_ready=0 for in_fu_sel=1 while in_fu_sel=0 still accepts. One rs_issue[1] -> credit 1, next MUL accept taken one cycle later.
- Same cycle accept to DIV and rs_issue[2] at credit 5 -> credit stays 5, rs_start[2] pulses.
- After 10 accepts (seq=10), assert flush concurrent with in_valid -> no rs_start next cycle, all credits 32, next accepted rs_seq=10.
- rs_issue[3] with BR credit 32 -> credit stays 32, credit_err=1 and stays set after flush; cleared only by reset.
- RS_DISPATCH_PERF_EN defined: hold in_valid to full ALU for 7 cycles -> stall_cnt ALU=7, other RS counters 0. Undefined: all stall_cnt read 0.
